// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic_rotator engine: FSM states,
// CORDIC gain, angle limit and the Q2.14 arctangent table.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [15:0] CORDIC_K = 16'sd9949;
    localparam logic signed [15:0] HALF_PI  = 16'sd25736;

    // atan(2^-i) in Q2.14; the last entry rounds to zero at this precision
    localparam logic signed [15:0] ATAN_LUT [0:15] = '{
        16'sd12868, 16'sd7596, 16'sd4014, 16'sd2037,
        16'sd1023,  16'sd512,  16'sd256,  16'sd128,
        16'sd64,    16'sd32,   16'sd16,   16'sd8,
        16'sd4,     16'sd2,    16'sd1,    16'sd0
    };

endpackage

// File: rtl/cordic_rotator_if.sv
// Angle-in / vector-out handshake bundle of the CORDIC rotator.
interface cordic_rotator_if;

    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  angle;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  cos_out;
    logic signed [15:0]  sin_out;
    logic                range_err;

    modport master (
        output in_valid, angle, out_ready,
        input  in_ready, out_valid, cos_out, sin_out, range_err
    );

    modport slave (
        input  in_valid, angle, out_ready,
        output in_ready, out_valid, cos_out, sin_out, range_err
    );

endinterface

// File: rtl/adder.sv
// Parameterised ripple-carry adder; sum wraps modulo 2^n.
module adder #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[n];

endmodule

// File: rtl/cordic_addsub.sv
// Add/subtract around one 16-bit ripple adder: i_op = 1 gives a - b as a + ~b + 1.
module cordic_addsub (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_op,
    output logic [15:0] o_sum
);

    logic [15:0] w_b;
    logic        w_cout_unused;

    assign w_b = i_op ? ~i_b : i_b;

    adder #(.n(16)) u_adder (
        .a    (i_a),
        .b    (w_b),
        .cin  (i_op),
        .sum  (o_sum),
        .cout (w_cout_unused)
    );

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing
// cos/sin of a Q2.14 angle in [-pi/2, +pi/2].
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int N_ITER = 16,
    parameter int W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_rotator_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic signed [W-1:0] r_x, r_y, r_z;
    logic signed [W-1:0] r_cos, r_sin;
    logic [3:0]          r_i;
    logic                r_range_err;

    logic                w_z_pos;
    logic signed [W-1:0] w_x_shift, w_y_shift, w_atan;
    logic signed [W-1:0] w_x_sum, w_y_sum, w_z_sum;
    logic                w_accept, w_in_range, w_last;

    assign w_z_pos    = ~r_z[W-1];
    assign w_x_shift  = r_x >>> r_i;
    assign w_y_shift  = r_y >>> r_i;
    assign w_atan     = ATAN_LUT[r_i];
    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_in_range = (bus.angle <= HALF_PI) && (bus.angle >= -HALF_PI);
    assign w_last     = (r_i == 4'(N_ITER - 1));

    // d = +1 (z >= 0): x subtracts, y adds, z subtracts; all flip for d = -1
    cordic_addsub u_x (.i_a(r_x), .i_b(w_y_shift), .i_op(w_z_pos),  .o_sum(w_x_sum));
    cordic_addsub u_y (.i_a(r_y), .i_b(w_x_shift), .i_op(~w_z_pos), .o_sum(w_y_sum));
    cordic_addsub u_z (.i_a(r_z), .i_b(w_atan),    .i_op(w_z_pos),  .o_sum(w_z_sum));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_in_range) w_state_next = ROT;
            ROT:     if (w_last)                 w_state_next = DONE;
            DONE:    if (bus.out_ready)          w_state_next = IDLE;
            default:                             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_i         <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_range_err <= w_accept && !w_in_range;
            if (r_state == IDLE && w_accept && w_in_range) begin
                r_x <= CORDIC_K;
                r_y <= '0;
                r_z <= bus.angle;
                r_i <= '0;
            end else if (r_state == ROT) begin
                r_x <= w_x_sum;
                r_y <= w_y_sum;
                r_z <= w_z_sum;
                r_i <= r_i + 4'd1;
                // result registers take the final iteration's sums directly
                if (w_last) begin
                    r_cos <= w_x_sum;
                    r_sin <= w_y_sum;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.cos_out   = r_cos;
    assign bus.sin_out   = r_sin;
    assign bus.range_err = r_range_err;

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed-vector bench for cordic_rotator with hand-computed expectations.
module tb_cordic_rotator;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cordic_rotator_if bus ();

    cordic_rotator #(.N_ITER(16), .W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        total++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic accept(input int a);
        int n;
        @(negedge clk);
        bus.angle    = 16'(a);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", int'(n < 50), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 40);
        chk("out_valid_seen", int'(bus.out_valid), 1);
    endtask

    task automatic handshake(input int exp_cos, input int exp_sin);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_out_valid_low", int'(bus.out_valid), 0);
        chk("hs_in_ready_high", int'(bus.in_ready), 1);
        chk("hs_cos_retained", int'(bus.cos_out), exp_cos, 4);
        chk("hs_sin_retained", int'(bus.sin_out), exp_sin, 4);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input int a, input int exp_cos, input int exp_sin);
        int lat;
        accept(a);
        wait_out(lat);
        chk("latency", lat, 16);
        chk("cos", int'(bus.cos_out), exp_cos, 4);
        chk("sin", int'(bus.sin_out), exp_sin, 4);
        $display("vec angle=%0d cos=%0d sin=%0d latency=%0d", a, bus.cos_out, bus.sin_out, lat);
        handshake(exp_cos, exp_sin);
    endtask

    task automatic run_oor(input int a, input int prev_cos, input int prev_sin);
        @(negedge clk);
        bus.angle    = 16'(a);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("oor_range_err", int'(bus.range_err), 1);
        chk("oor_in_ready", int'(bus.in_ready), 1);
        chk("oor_out_valid", int'(bus.out_valid), 0);
        chk("oor_cos_kept", int'(bus.cos_out), prev_cos, 4);
        @(posedge clk);
        #1;
        chk("oor_pulse_one_cycle", int'(bus.range_err), 0);
        chk("oor_no_out_valid", int'(bus.out_valid), 0);
        $display("oor angle=%0d prev sin=%0d", a, prev_sin);
    endtask

    initial begin
        int lat;
        int busy_ready;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.angle     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_cos", int'(bus.cos_out), 0);
        chk("rst_sin", int'(bus.sin_out), 0);
        chk("rst_range_err", int'(bus.range_err), 0);
        $display("reset released");
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, 16384, 0);
        run_vec(12868, 11585, 11585);
        run_vec(-25736, 0, -16384);

        run_oor(30000, 0, -16384);
        run_oor(-30000, 0, -16384);
        run_oor(25737, 0, -16384);

        // busy: a new angle held during ROT must wait, then backpressure in DONE
        accept(12868);
        @(negedge clk);
        bus.angle    = 16'sd0;
        bus.in_valid = 1'b1;
        busy_ready   = 0;
        lat          = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            if (bus.in_ready) busy_ready++;
            lat++;
        end
        chk("busy_in_ready_low", busy_ready, 0);
        chk("busy_out_valid", int'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid_held", int'(bus.out_valid), 1);
            chk("bp_cos_stable", int'(bus.cos_out), 11585, 4);
            chk("bp_sin_stable", int'(bus.sin_out), 11585, 4);
        end
        $display("backpressure cos=%0d sin=%0d", bus.cos_out, bus.sin_out);
        handshake(11585, 11585);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("held_angle_accepted", int'(bus.in_ready), 0);
        wait_out(lat);
        chk("held_cos", int'(bus.cos_out), 16384, 4);
        chk("held_sin", int'(bus.sin_out), 0, 4);
        $display("held angle=0 cos=%0d sin=%0d", bus.cos_out, bus.sin_out);
        handshake(16384, 0);

        // asynchronous reset in the middle of a rotation
        accept(12868);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        chk("mid_rst_cos", int'(bus.cos_out), 0);
        chk("mid_rst_sin", int'(bus.sin_out), 0);
        chk("mid_rst_range_err", int'(bus.range_err), 0);
        $display("mid-rotation reset applied");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(12868, 11585, 11585);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
